demod_rx: RTL

Receive-side demodulator for the 7-bit sample stream produced by the modulator in the top (`uo_out[6:0]` path). It takes one unsigned 7-bit sample per valid cycle, removes the mid-scale offset and integrates over fixed-length symbols. It recovers one bit per symbol for ASK, FSK or BPSK, selected by the same 2-bit `sel` code the modulator uses. It sits behind the top's input pins and drives the demodulated bit on `uo_out[7]`.

---
 rtl/demod_pkg.sv | 19 +
 rtl/demod_rx_symbol_accum.sv | 85 ++++++++
 rtl/demod_rx.sv | 91 +++++++++
 3 files changed

// File: rtl/demod_pkg.sv
// Shared encodings and sizing helpers for the sample-stream modulator/demodulator pair.
// Pure declarations: no logic, no latency, no flow control.
package demod_pkg;

  typedef enum logic [1:0] {
    MODE_ASK    = 2'b00,
    MODE_FSK    = 2'b01,
    MODE_PSK    = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_e;

  localparam int MIDSCALE = 64;

  // Unsigned width holding the sum of SPS magnitudes of up to 64.
  function automatic int energy_w(input int sps);
    return $clog2(64 * sps) + 1;
  endfunction

endpackage

// File: rtl/demod_rx_symbol_accum.sv
// Per-symbol index and energy/correlation/crossing accumulators; *_final outputs are combinational and include the current sample.
// No backpressure: a sample is taken whenever ena && sample_valid; clear restarts the symbol.
module symbol_accum
  import demod_pkg::*;
#(
  parameter int SPS = 16,
  parameter int EW  = energy_w(SPS),
  parameter int CW  = EW + 1,
  parameter int XW  = $clog2(SPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic [6:0]           sample_in,
  output logic                 accept,
  output logic                 last,
  output logic [EW-1:0]        energy_final,
  output logic signed [CW-1:0] corr_final,
  output logic [XW-1:0]        xing_final
);

  localparam int IW = $clog2(SPS);
  localparam logic [IW-1:0] IDX_LAST = IW'(SPS - 1);
  localparam logic [IW-1:0] IDX_HALF = IW'(SPS / 2);

  logic [IW-1:0]        idx;
  logic [EW-1:0]        energy;
  logic signed [CW-1:0] corr;
  logic [XW-1:0]        xing;
  logic                 prev_pos;

  logic signed [7:0]    s;
  logic signed [7:0]    term;
  logic [6:0]           mag;
  logic                 pos;
  logic                 first;
  logic [IW-1:0]        idx_eff;
  logic [EW-1:0]        energy_base;
  logic signed [CW-1:0] corr_base;

  always_comb begin
    s           = signed'({1'b0, sample_in} - 8'(MIDSCALE));
    pos         = ~s[7];
    mag         = pos ? s[6:0] : 7'(-s);
    // A clear in the same cycle makes this sample index 0 of a fresh symbol.
    first       = clear || (idx == '0);
    idx_eff     = clear ? '0 : idx;
    term        = (idx_eff < IDX_HALF) ? s : -s;
    energy_base = first ? '0 : energy;
    corr_base   = first ? '0 : corr;
    energy_final = energy_base + EW'(mag);
    corr_final   = corr_base + CW'(term);
    xing_final   = '0;
    if (!first) begin
      xing_final = xing;
      if ((pos != prev_pos) && (xing != '1)) xing_final = xing + 1'b1;
    end
    accept = ena && sample_valid;
    last   = !clear && (idx == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      energy   <= '0;
      corr     <= '0;
      xing     <= '0;
      prev_pos <= 1'b0;
    end else if (accept) begin
      idx      <= last ? '0 : idx_eff + 1'b1;
      energy   <= energy_final;
      corr     <= corr_final;
      xing     <= xing_final;
      prev_pos <= pos;
    end else if (ena && clear) begin
      idx    <= '0;
      energy <= '0;
      corr   <= '0;
      xing   <= '0;
    end
  end

endmodule

// File: rtl/demod_rx.sv
// ASK/FSK/BPSK symbol demodulator with bypass comparator; decisions are registered one cycle after the last sample.
// No backpressure: samples are consumed on sample_valid, ena low freezes the block.
module demod_rx
  import demod_pkg::*;
#(
  parameter int SPS        = 16,
  parameter int ASK_THRESH = 256,
  parameter int FSK_XING   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] sel,
  input  logic [6:0] sample_in,
  input  logic       sample_valid,
  input  logic       sym_sync,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       demod_out,
  output logic       carrier_det
);

  localparam int EW = energy_w(SPS);
  localparam int CW = EW + 1;
  localparam int XW = $clog2(SPS);

  logic [1:0]           sel_q;
  logic                 sel_chg;
  logic                 clear;
  logic                 valid_eff;
  logic                 accept;
  logic                 last;
  logic [EW-1:0]        energy_final;
  logic signed [CW-1:0] corr_final;
  logic [XW-1:0]        xing_final;
  logic                 cd_next;
  logic                 dec_bit;
  logic                 decide;

  // A mode change flushes like sym_sync, and the sample arriving with it is dropped.
  always_comb begin
    sel_chg   = (sel != sel_q);
    clear     = sym_sync || sel_chg;
    valid_eff = sample_valid && !sel_chg;
    cd_next   = int'(energy_final) >= ASK_THRESH;
    dec_bit   = 1'b0;
    case (sel)
      MODE_ASK: dec_bit = cd_next;
      MODE_FSK: dec_bit = int'(xing_final) >= FSK_XING;
      MODE_PSK: dec_bit = !corr_final[CW-1];
      default:  dec_bit = 1'b0;
    endcase
    decide = accept && last && (sel != MODE_BYPASS);
  end

  symbol_accum #(.SPS(SPS), .EW(EW), .CW(CW), .XW(XW)) u_accum (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .clear        (clear),
    .sample_valid (valid_eff),
    .sample_in    (sample_in),
    .accept       (accept),
    .last         (last),
    .energy_final (energy_final),
    .corr_final   (corr_final),
    .xing_final   (xing_final)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q       <= sel;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      demod_out   <= 1'b0;
      carrier_det <= 1'b0;
    end else begin
      // Pulse output: drops back to 0 even while disabled so it never stretches.
      bit_valid <= decide;
      if (ena) sel_q <= sel;
      if (decide) begin
        bit_out     <= dec_bit;
        demod_out   <= dec_bit;
        carrier_det <= cd_next;
      end else if (accept && (sel == MODE_BYPASS)) begin
        demod_out <= ~sample_in[6];
      end
    end
  end

endmodule
